// File: rtl/lsu_pipeline_if.sv
// EX/MEM input, data-bus and WB output signals of the memory stage.
// The slave modport is the stage itself; master is its environment.
interface lsu_pipeline_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_result;
  logic [31:0] in_rs2_data;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        in_reg_wen;
  logic        in_mem_ren;
  logic        in_mem_wen;
  logic        in_is_csr;
  logic [31:0] in_csr_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_wen;
  logic [31:0] out_wdata;

  logic        busy;
  // Encoded FSM state: 0 = IDLE, 1 = REQ, 2 = WAIT.
  logic [1:0]  dbg_state;

  modport slave (
    input  in_valid, in_pc, in_alu_result, in_rs2_data, in_rd, in_funct3,
           in_reg_wen, in_mem_ren, in_mem_wen, in_is_csr, in_csr_rdata,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, out_valid, out_pc, out_rd, out_reg_wen, out_wdata,
           busy, dbg_state
  );

  modport master (
    output in_valid, in_pc, in_alu_result, in_rs2_data, in_rd, in_funct3,
           in_reg_wen, in_mem_ren, in_mem_wen, in_is_csr, in_csr_rdata,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, out_valid, out_pc, out_rd, out_reg_wen, out_wdata,
           busy, dbg_state
  );
endinterface

// File: rtl/lsu_pipeline.sv
// Memory stage: passes ALU/CSR results through one output register and runs
// loads/stores on a request/response bus with strobe generation and load extension.
//
// Handshakes: every channel (in_*, mem_req_*, out_*) transfers on a rising edge
// where valid && ready; the sender holds valid and payload stable until then.
// mem_rsp_valid has no ready and is a single-cycle pulse, only honoured in WAIT.
module lsu_pipeline (
  input  logic            clk,
  input  logic            rst,
  lsu_pipeline_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_alu;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic        r_reg_wen;

  logic        r_req_valid;
  logic [31:0] r_req_addr;
  logic        r_req_wen;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_wstrb;

  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [4:0]  r_out_rd;
  logic        r_out_reg_wen;
  logic [31:0] r_out_wdata;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_is_mem;
  logic [3:0]  w_st_strb;
  logic [31:0] w_st_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_val;

  assign w_in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mem   = bus.in_mem_ren || bus.in_mem_wen;

  // Store lane placement; strobe bits shifted past bit 3 fall off the 4-bit result.
  always_comb begin
    w_st_strb  = 4'b1111;
    w_st_wdata = bus.in_rs2_data;
    case (bus.in_funct3)
      3'b000: begin
        w_st_strb  = 4'b0001 << bus.in_alu_result[1:0];
        w_st_wdata = {4{bus.in_rs2_data[7:0]}};
      end
      3'b001: begin
        w_st_strb  = 4'b0011 << bus.in_alu_result[1:0];
        w_st_wdata = {2{bus.in_rs2_data[15:0]}};
      end
      default: begin
        w_st_strb  = 4'b1111;
        w_st_wdata = bus.in_rs2_data;
      end
    endcase
  end

  assign w_shifted = bus.mem_rsp_rdata >> {r_alu[1:0], 3'b000};

  always_comb begin
    w_load_val = bus.mem_rsp_rdata;
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_val = {24'd0, w_shifted[7:0]};
      3'b001:  w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_val = {16'd0, w_shifted[15:0]};
      default: w_load_val = bus.mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_alu         <= '0;
      r_rd          <= '0;
      r_funct3      <= '0;
      r_reg_wen     <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_req_wen     <= 1'b0;
      r_req_wdata   <= '0;
      r_req_wstrb   <= '0;
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_rd      <= '0;
      r_out_reg_wen <= 1'b0;
      r_out_wdata   <= '0;
    end else begin
      // Drain first; a same-cycle load below takes priority.
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_mem) begin
              r_pc        <= bus.in_pc;
              r_alu       <= bus.in_alu_result;
              r_rd        <= bus.in_rd;
              r_funct3    <= bus.in_funct3;
              r_reg_wen   <= bus.in_reg_wen;
              r_req_valid <= 1'b1;
              r_req_addr  <= {bus.in_alu_result[31:2], 2'b00};
              r_req_wen   <= bus.in_mem_wen;
              r_req_wdata <= bus.in_mem_wen ? w_st_wdata : 32'd0;
              r_req_wstrb <= bus.in_mem_wen ? w_st_strb : 4'd0;
              r_state     <= REQ;
            end else begin
              r_out_valid   <= 1'b1;
              r_out_pc      <= bus.in_pc;
              r_out_rd      <= bus.in_rd;
              r_out_reg_wen <= bus.in_reg_wen;
              r_out_wdata   <= bus.in_is_csr ? bus.in_csr_rdata : bus.in_alu_result;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            r_req_valid <= 1'b0;
            if (r_req_wen) begin
              // Stores are posted: retire to WB as soon as the bus takes them.
              r_out_valid   <= 1'b1;
              r_out_pc      <= r_pc;
              r_out_rd      <= r_rd;
              r_out_reg_wen <= r_reg_wen;
              r_out_wdata   <= r_alu;
              r_state       <= IDLE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            r_out_valid   <= 1'b1;
            r_out_pc      <= r_pc;
            r_out_rd      <= r_rd;
            r_out_reg_wen <= r_reg_wen;
            r_out_wdata   <= w_load_val;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_wen   = r_req_wen;
  assign bus.mem_req_wdata = r_req_wdata;
  assign bus.mem_req_wstrb = r_req_wstrb;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pc        = r_out_pc;
  assign bus.out_rd        = r_out_rd;
  assign bus.out_reg_wen   = r_out_reg_wen;
  assign bus.out_wdata     = r_out_wdata;
  assign bus.busy          = (r_state != IDLE);
  assign bus.dbg_state     = r_state;

endmodule

// File: doc/lsu_pipeline.md
# lsu_pipeline

Memory stage of the pipelined core: sits between the EX/MEM interface driven by the execution unit and the write-back stage. It accepts one execute result per valid/ready handshake and passes non-memory results through a single output register. Loads and stores are issued on a request/response data bus, with byte-strobe generation for stores and sign/zero extension for loads. The final register write-back value is then presented to WB.

## Interface
No parameters (XLEN fixed at 32).
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX result valid
- in_ready  out  1  stage can accept
- in_pc  in  32  instruction PC
- in_alu_result  in  32  ALU result / effective address
- in_rs2_data  in  32  store data
- in_rd  in  5  destination register
- in_funct3  in  3  access size/sign
- in_reg_wen  in  1  writes rd
- in_mem_ren  in  1  load
- in_mem_wen  in  1  store
- in_is_csr  in  1  CSR instruction
- in_csr_rdata  in  32  old CSR value (rd result for CSR ops)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_req_wen  out  1  1=write, 0=read
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wstrb  out  4  byte strobes (0 for reads)
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  32  read word
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB accepts
- out_pc  out  32  passthrough PC
- out_rd  out  5  destination register
- out_reg_wen  out  1  write enable
- out_wdata  out  32  write-back value
- busy  out  1  state != IDLE (used by hazard unit)

## Operation
- States: IDLE, REQ, WAIT.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept in IDLE, non-memory: load output register; out_wdata = in_is_csr ? in_csr_rdata : in_alu_result; stay IDLE.
- Accept in IDLE, load or store: latch all fields; go to REQ.
- REQ: mem_req_valid=1; signals held stable until mem_req_ready.
  - Store handshake: output register loaded (out_reg_wen = latched reg_wen, normally 0; out_wdata = alu_result); go to IDLE. Stores are posted, with no response.
  - Load handshake: go to WAIT.
- WAIT: on mem_rsp_valid, extract and extend, load output register, go to IDLE.
- mem_rsp_valid outside WAIT is ignored. The responder never returns data in the same cycle as the request handshake.
- Store strobes with a = addr[1:0]:
  - SB (000): 4'b0001<<a, wdata = {4{rs2[7:0]}}.
  - SH (001): 4'b0011<<a, wdata = {2{rs2[15:0]}}.
  - SW (010): 4'b1111, wdata = rs2.
  - Strobe bits shifted past bit 3 are dropped.
- Load extraction: shifted = rdata >> (8*a).
  - LB: sext shifted[7:0]; LBU: zext shifted[7:0].
  - LH: sext shifted[15:0]; LHU: zext shifted[15:0].
  - LW: rdata. Other funct3 values: rdata.
- Misalignment gets no trap; the lane-shift result is as defined above.
- The output register is always empty in REQ/WAIT, so no overwrite is possible.
- The output register holds until out_valid && out_ready. A same-cycle drain plus accept of a non-mem entry is allowed.

## Timing
- Reset values: state IDLE; out_valid, mem_req_valid, busy = 0; all data outputs 0.
- Reset mid-REQ/WAIT aborts the access. A late mem_rsp_valid after reset is ignored.
- Latency, accept to out_valid:
  - Non-mem: 1 cycle.
  - Store: 1 + req wait cycles.
  - Load: 1 + req wait + rsp wait + 1.
- mem_req_valid rises the cycle after accept, registered. All mem_req_* are registered outputs.
- Throughput: non-mem one per cycle with out_ready=1. No accept while busy.
- Held out_* do not change while out_valid && !out_ready.

## Test plan
- ALU passthrough: back-to-back adds, rd=5 alu=0x1234, out_ready=1 -> out_valid each cycle with 1-cycle latency, out_wdata=0x1234.
- LB sign: addr 0x80000003, rdata 0x80FF0011 -> mem_req_addr 0x80000000, out_wdata 0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at addr 0x...2, rs2 0xABCD1234 -> wstrb 4'b1100, wdata 0x12341234, wen=1. No WB write.
- Bus stall: mem_req_ready low 3 cycles, then rsp 2 cycles later -> req fields stable, in_ready=0 and busy=1 throughout, single out_valid.
- WB backpressure: out_ready=0 for 4 cycles with a second entry pending -> in_ready=0, out_* stable, second entry accepted on the drain cycle.
- Reset in WAIT, then rsp_valid pulse -> state IDLE, out_valid stays 0, no write.
